// File: rtl/shift_collector.sv
// Serial-in, parallel-out byte collector: gathers MSB-first or LSB-first bits into a byte,
// with early flush and zero/sign-fill realignment of LSB-first partial frames.
module shift_collector (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_bit,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       direction,
    input  logic       arithmetic,
    input  logic       flush,
    output logic [7:0] out_byte,
    output logic [3:0] out_count,
    output logic       out_valid,
    input  logic       out_ready
);

    typedef enum logic [1:0] {IDLE, COLLECT, ALIGN, HOLD} state_t;

    state_t     state_reg;
    logic [7:0] sh_reg;
    logic [3:0] count_reg;
    logic [3:0] remaining_reg;
    logic       dir_reg;
    logic       arith_reg;
    logic       in_ready_reg;
    logic       out_valid_reg;
    logic [7:0] out_byte_reg;
    logic [3:0] out_count_reg;

    logic       accept;
    logic       dir_eff;
    logic [7:0] shift_in;
    logic [3:0] count_inc;
    logic [7:0] align_sh;
    logic [7:0] frame_sh;
    logic [3:0] frame_count;
    logic       frame_end;

    // On the first bit of a frame the order comes straight from the input, not the latch.
    assign accept      = in_valid && in_ready_reg;
    assign dir_eff     = (state_reg == IDLE) ? direction : dir_reg;
    assign shift_in    = dir_eff ? {sh_reg[6:0], in_bit} : {in_bit, sh_reg[7:1]};
    assign count_inc   = count_reg + 4'd1;
    assign align_sh    = {arith_reg & sh_reg[7], sh_reg[7:1]};
    assign frame_sh    = accept ? shift_in : sh_reg;
    assign frame_count = accept ? count_inc : count_reg;
    assign frame_end   = accept ? ((count_inc == 4'd8) || flush)
                                : (flush && (state_reg == COLLECT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            sh_reg        <= 8'h00;
            count_reg     <= 4'd0;
            remaining_reg <= 4'd0;
            dir_reg       <= 1'b0;
            arith_reg     <= 1'b0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            out_byte_reg  <= 8'h00;
            out_count_reg <= 4'd0;
        end else begin
            case (state_reg)
                IDLE, COLLECT: begin
                    if (accept) begin
                        sh_reg    <= shift_in;
                        count_reg <= count_inc;
                        if (state_reg == IDLE) begin
                            dir_reg   <= direction;
                            arith_reg <= arithmetic;
                        end
                    end
                    if (frame_end) begin
                        in_ready_reg <= 1'b0;
                        // Left-order partials are already right-justified; right-order needs realignment.
                        if ((frame_count == 4'd8) || dir_eff) begin
                            state_reg     <= HOLD;
                            out_byte_reg  <= frame_sh;
                            out_count_reg <= frame_count;
                            out_valid_reg <= 1'b1;
                        end else begin
                            state_reg     <= ALIGN;
                            remaining_reg <= 4'd8 - frame_count;
                        end
                    end else if (accept) begin
                        state_reg <= COLLECT;
                    end
                end
                ALIGN: begin
                    sh_reg        <= align_sh;
                    remaining_reg <= remaining_reg - 4'd1;
                    if (remaining_reg == 4'd1) begin
                        state_reg     <= HOLD;
                        out_byte_reg  <= align_sh;
                        out_count_reg <= count_reg;
                        out_valid_reg <= 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_reg     <= IDLE;
                        sh_reg        <= 8'h00;
                        count_reg     <= 4'd0;
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_byte  = out_byte_reg;
    assign out_count = out_count_reg;

endmodule
